// File: rtl/out_port_sched.sv
// out_port_sched: per-output-port switch scheduler with round-robin arbitration and per-VC credits.
// Optional wormhole packet locking is enabled by defining OUT_PORT_SCHED_PKT_LOCK_EN.
module out_port_sched #(
  parameter int NUM_IN   = 4,
  parameter int NUM_VC   = 4,
  parameter int VCW      = 5,
  parameter int CRED_MAX = 8,
  parameter int CW       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_IN-1:0]     req,
  input  logic [NUM_IN*VCW-1:0] req_vc,
  input  logic [NUM_IN-1:0]     req_tail,
  input  logic                  cr_valid,
  input  logic [VCW-1:0]        cr_vc,
  input  logic                  cfg_we,
  input  logic [CW-1:0]         cfg_credits,
  output logic [NUM_IN-1:0]     gnt,
  output logic                  gnt_valid,
  output logic [VCW-1:0]        gnt_vc,
  output logic [NUM_VC-1:0]     credit_avail,
  output logic                  cr_err
);

  localparam int              PW       = $clog2(NUM_IN);
  localparam int              VIW      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam logic [VCW:0]    NUM_VC_W = (VCW+1)'(NUM_VC);
  localparam logic [CW-1:0]   CMAX     = CW'(CRED_MAX);

  typedef enum logic [1:0] {IDLE, ARB, HOLD} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr, ptr_nxt, win, idx;
  logic [PW:0]       sum;
  logic [CW-1:0]     cnt [NUM_VC];
  logic [VCW-1:0]    in_vc [NUM_IN];
  logic [NUM_IN-1:0] elig;
  logic              found, issue, win_tail, adv;
  logic [VCW-1:0]    win_vc;
  logic [NUM_VC-1:0] dec_v, inc_v, at_max;
  logic              cr_in_rng, cr_err_set;
  logic [CW-1:0]     cfg_load;

`ifdef OUT_PORT_SCHED_PKT_LOCK_EN
  logic [PW-1:0]     lock_in;
  logic [VCW-1:0]    lock_vc;
`else
  logic              unused_tail;
  assign unused_tail = ^req_tail;
`endif

  for (genvar g = 0; g < NUM_IN; g++) begin : g_vc
    assign in_vc[g] = req_vc[g*VCW +: VCW];
  end

  // Eligibility uses the counter value before this cycle's update.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    elig = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      elig[i] = req[i] && ({1'b0, in_vc[i]} < NUM_VC_W) && (cnt[in_vc[i][VIW-1:0]] != '0);
`ifdef OUT_PORT_SCHED_PKT_LOCK_EN
      if (state == HOLD)
        elig[i] = elig[i] && (PW'(i) == lock_in) && (in_vc[i] == lock_vc);
`endif
    end
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_IN)) sum = sum - (PW+1)'(NUM_IN);
      idx = sum[PW-1:0];
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    issue    = found && !cfg_we;
    win_vc   = in_vc[win];
    win_tail = req_tail[win];
    ptr_nxt  = (win == PW'(NUM_IN-1)) ? '0 : win + 1'b1;
`ifdef OUT_PORT_SCHED_PKT_LOCK_EN
    adv = issue && win_tail;
`else
    adv = issue;
`endif
  end

  always_comb begin
    dec_v        = '0;
    inc_v        = '0;
    at_max       = '0;
    credit_avail = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      dec_v[v]        = issue && (win_vc == VCW'(v));
      inc_v[v]        = cr_valid && (cr_vc == VCW'(v));
      at_max[v]       = (cnt[v] == CMAX);
      credit_avail[v] = (cnt[v] != '0);
    end
  end

  assign cr_in_rng  = ({1'b0, cr_vc} < NUM_VC_W);
  assign cfg_load   = (cfg_credits > CMAX) ? CMAX : cfg_credits;
  // A grant and a return on the same VC cancel, so that case never overflows.
  assign cr_err_set = cr_valid && !cfg_we && (!cr_in_rng || |(inc_v & at_max & ~dec_v));
  assign gnt_valid  = |gnt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req)  state_nxt = ARB;
      ARB:     if (!(|req)) state_nxt = IDLE;
      default: state_nxt = state;
    endcase
`ifdef OUT_PORT_SCHED_PKT_LOCK_EN
    if (issue) state_nxt = win_tail ? ARB : HOLD;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      gnt    <= '0;
      gnt_vc <= '0;
      cr_err <= 1'b0;
      // NOTE: the counter array is state the function depends on, so every entry is reset.
      for (int v = 0; v < NUM_VC; v++) cnt[v] <= CMAX;
    end else begin
      state  <= state_nxt;
      gnt    <= issue ? (NUM_IN'(1) << win) : '0;
      gnt_vc <= issue ? win_vc : '0;
      if (adv)        ptr    <= ptr_nxt;
      if (cr_err_set) cr_err <= 1'b1;
      for (int v = 0; v < NUM_VC; v++) begin
        if (cfg_we)
          cnt[v] <= cfg_load;
        else if (dec_v[v] && !inc_v[v])
          cnt[v] <= cnt[v] - 1'b1;
        else if (inc_v[v] && !dec_v[v] && !at_max[v])
          cnt[v] <= cnt[v] + 1'b1;
      end
    end
  end

`ifdef OUT_PORT_SCHED_PKT_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_in <= '0;
      lock_vc <= '0;
    end else if (issue && !win_tail) begin
      lock_in <= win;
      lock_vc <= win_vc;
    end
  end
`endif

endmodule
